mem_lsu: RTL and testbench

//  MEM-stage load/store unit: turns the EX/MEM memory op into a valid/ready data-memory transaction.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 62 ++++++
 rtl/mem_lsu.sv | 154 +++++++++++++++
 tb/tb_mem_lsu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds the RV32I load/store funct3 codes, the FSM states and the store lane payload.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] wdata;
  } lsu_store_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data replication and load byte/half extract + extend.
// The store side sees only the size bits; stores with funct3 >= 3 never reach it.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output lsu_store_t  st,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lanes: data replicated across the word, strobes select the addressed bytes
  always_comb begin
    st.strb  = 4'hF;
    st.wdata = st_data;
    case (st_size)
      2'b00: begin
        st.strb  = 4'b0001 << st_addr_lo;
        st.wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st.strb  = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st.wdata = {2{st_data[15:0]}};
      end
      default: begin
        st.strb  = 4'hF;
        st.wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  end

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = ld_rdata;
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: converts the EX/MEM memory op into a valid/ready data-memory
// transaction, stalling the pipeline until the response (or a wait timeout) completes it.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_valid,
  input  logic              M_mem_read,
  input  logic              M_mem_write,
  input  logic [2:0]        M_funct3,
  input  logic [ADDR_W-1:0] M_alu_out,
  input  logic [31:0]       M_rs2_data,
  output logic              M_stall,
  output logic [31:0]       M_load_data,
  output logic              M_mem_fault,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_we,
  output logic [ADDR_W-1:0] dm_req_addr,
  output logic [31:0]       dm_req_wdata,
  output logic [3:0]        dm_req_strb,
  input  logic              dm_rsp_valid,
  input  logic [31:0]       dm_rsp_rdata
);

  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  lsu_state_t  state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        timed_out;

  logic        access, illegal, is_half, is_word, lo_nz;
  logic        capture, cnt_clr, cnt_inc, rsp_take, to_take, timeout_hit;
  lsu_store_t  st;
  logic [31:0] ld_value;

  lsu_align u_align (
    .st_size    (M_funct3[1:0]),
    .st_addr_lo (M_alu_out[1:0]),
    .st_data    (M_rs2_data),
    .st         (st),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_rdata   (dm_rsp_rdata),
    .ld_data    (ld_value)
  );

  // Access classification against the incoming MEM-stage op
  always_comb begin
    access  = M_valid & (M_mem_read | M_mem_write);
    is_half = (M_funct3 == F3_H) | (M_funct3 == F3_HU);
    is_word = (M_funct3 == F3_W);
    lo_nz   = |M_alu_out[1:0];
    illegal = (M_mem_read & M_mem_write)
            | (M_funct3 == 3'd3) | (M_funct3 == 3'd6) | (M_funct3 == 3'd7)
            | (M_mem_write & (M_funct3 >= 3'd3))
            | (is_half & M_alu_out[0])
            | (is_word & lo_nz);
    timeout_hit = (WAIT_LIMIT != 0) && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    M_stall      = 1'b0;
    M_mem_fault  = 1'b0;
    dm_req_valid = 1'b0;
    capture      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    rsp_take     = 1'b0;
    to_take      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            M_mem_fault = 1'b1;
          end else begin
            M_stall   = 1'b1;
            capture   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        M_stall      = 1'b1;
        dm_req_valid = 1'b1;
        if (dm_req_ready) begin
          cnt_clr   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        M_stall = 1'b1;
        if (dm_rsp_valid) begin
          rsp_take  = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          to_take   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        M_mem_fault = timed_out;
        state_nxt   = IDLE;
      end
    endcase
  end

  // Request fields, load context, wait counter and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req_we    <= 1'b0;
      dm_req_addr  <= '0;
      dm_req_wdata <= 32'h0;
      dm_req_strb  <= 4'h0;
      ld_funct3    <= 3'h0;
      ld_addr_lo   <= 2'h0;
      wait_cnt     <= '0;
      timed_out    <= 1'b0;
      M_load_data  <= 32'h0;
    end else begin
      if (capture) begin
        dm_req_we    <= M_mem_write;
        dm_req_addr  <= {M_alu_out[ADDR_W-1:2], 2'b00};
        dm_req_wdata <= M_mem_write ? st.wdata : 32'h0;
        dm_req_strb  <= M_mem_write ? st.strb : 4'h0;
        ld_funct3    <= M_funct3;
        ld_addr_lo   <= M_alu_out[1:0];
        timed_out    <= 1'b0;
      end
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + CNT_W'(1);
      if (rsp_take && !dm_req_we) M_load_data <= ld_value;
      if (to_take) begin
        M_load_data <= 32'h0;
        timed_out   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu (WAIT_LIMIT = 8).
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid, M_mem_read, M_mem_write;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_out, M_rs2_data;
  logic        M_stall, M_mem_fault;
  logic [31:0] M_load_data;
  logic        dm_req_valid, dm_req_ready, dm_req_we;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic [3:0]  dm_req_strb;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_rdata;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.ADDR_W(32), .WAIT_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .M_valid      (M_valid),
    .M_mem_read   (M_mem_read),
    .M_mem_write  (M_mem_write),
    .M_funct3     (M_funct3),
    .M_alu_out    (M_alu_out),
    .M_rs2_data   (M_rs2_data),
    .M_stall      (M_stall),
    .M_load_data  (M_load_data),
    .M_mem_fault  (M_mem_fault),
    .dm_req_valid (dm_req_valid),
    .dm_req_ready (dm_req_ready),
    .dm_req_we    (dm_req_we),
    .dm_req_addr  (dm_req_addr),
    .dm_req_wdata (dm_req_wdata),
    .dm_req_strb  (dm_req_strb),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rsp_rdata (dm_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0;
    M_funct3 = f3; M_alu_out = addr; dm_req_ready = 1'b1; dm_rsp_valid = 1'b0;
    @(negedge clk);
    chk("ld_idle_stall", 32'(M_stall), 32'd1);
    chk("ld_idle_noreq", 32'(dm_req_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("ld_req_stall", 32'(M_stall), 32'd1);
    chk("ld_req_valid", 32'(dm_req_valid), 32'd1);
    chk("ld_req_we", 32'(dm_req_we), 32'd0);
    chk("ld_req_addr", dm_req_addr, addr & 32'hFFFF_FFFC);
    chk("ld_req_strb", 32'(dm_req_strb), 32'd0);
    cyc();
    dm_rsp_valid = 1'b1; dm_rsp_rdata = rdata;
    @(negedge clk);
    chk("ld_wait_stall", 32'(M_stall), 32'd1);
    chk("ld_wait_noreq", 32'(dm_req_valid), 32'd0);
    cyc();
    dm_rsp_valid = 1'b0;
    @(negedge clk);
    chk("ld_done_stall", 32'(M_stall), 32'd0);
    chk("ld_done_fault", 32'(M_mem_fault), 32'd0);
    chk("ld_data", M_load_data, exp);
    cyc();
  endtask

  task automatic store_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input int ready_lo, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [31:0] prev_ld);
    M_valid = 1'b1; M_mem_read = 1'b0; M_mem_write = 1'b1;
    M_funct3 = f3; M_alu_out = addr; M_rs2_data = rs2;
    dm_req_ready = (ready_lo == 0); dm_rsp_valid = 1'b0;
    @(negedge clk);
    chk("st_idle_stall", 32'(M_stall), 32'd1);
    cyc();
    for (int i = 0; i <= ready_lo; i++) begin
      if (i == ready_lo) dm_req_ready = 1'b1;
      @(negedge clk);
      chk("st_req_valid", 32'(dm_req_valid), 32'd1);
      chk("st_req_stall", 32'(M_stall), 32'd1);
      chk("st_req_we", 32'(dm_req_we), 32'd1);
      chk("st_req_addr", dm_req_addr, addr & 32'hFFFF_FFFC);
      chk("st_req_strb", 32'(dm_req_strb), 32'(exp_strb));
      chk("st_req_wdata", dm_req_wdata, exp_wdata);
      cyc();
    end
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("st_wait_stall", 32'(M_stall), 32'd1);
    cyc();
    dm_rsp_valid = 1'b0;
    @(negedge clk);
    chk("st_done_stall", 32'(M_stall), 32'd0);
    chk("st_done_fault", 32'(M_mem_fault), 32'd0);
    chk("st_ld_unchanged", M_load_data, prev_ld);
    cyc();
  endtask

  task automatic illegal_op(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
    M_valid = 1'b1; M_mem_read = rd; M_mem_write = wr; M_funct3 = f3; M_alu_out = addr;
    @(negedge clk);
    chk({tag, "_fault"}, 32'(M_mem_fault), 32'd1);
    chk({tag, "_stall"}, 32'(M_stall), 32'd0);
    chk({tag, "_noreq"}, 32'(dm_req_valid), 32'd0);
    cyc();
    M_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_stays_idle"}, 32'(dm_req_valid), 32'd0);
    chk({tag, "_fault_clr"}, 32'(M_mem_fault), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    M_valid = 1'b0; M_mem_read = 1'b0; M_mem_write = 1'b0;
    M_funct3 = 3'd0; M_alu_out = 32'h0; M_rs2_data = 32'h0;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_rdata = 32'h0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_stall", 32'(M_stall), 32'd0);
    chk("rst_fault", 32'(M_mem_fault), 32'd0);
    chk("rst_ld", M_load_data, 32'h0);
    chk("rst_valid", 32'(dm_req_valid), 32'd0);
    chk("rst_addr", dm_req_addr, 32'h0);
    chk("rst_strb", 32'(dm_req_strb), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Loads; the LB/LBU/LHU/LH group runs back to back with no idle gap
    load_op(3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_op(3'b000, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    load_op(3'b100, 32'h103, 32'h8011_2233, 32'h0000_0080);
    load_op(3'b101, 32'h102, 32'h8011_2233, 32'h0000_8011);
    load_op(3'b001, 32'h102, 32'h8011_2233, 32'hFFFF_8011);
    load_op(3'b000, 32'h101, 32'h8011_2233, 32'h0000_0022);
    M_valid = 1'b0;
    cyc();

    // Stores; SB holds ready low for 4 cycles to check field stability
    store_op(3'b000, 32'h201, 32'h0000_00A5, 4, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0022);
    store_op(3'b001, 32'h202, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0022);
    store_op(3'b010, 32'h204, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, 32'h0000_0022);
    M_valid = 1'b0;
    cyc();

    illegal_op("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h201);
    illegal_op("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h102);
    illegal_op("ld_f3_3", 1'b1, 1'b0, 3'b011, 32'h100);
    illegal_op("st_f3_4", 1'b0, 1'b1, 3'b100, 32'h100);
    illegal_op("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h100);

    // Non-memory op passes without stall
    M_valid = 1'b1; M_mem_read = 1'b0; M_mem_write = 1'b0;
    @(negedge clk);
    chk("alu_nostall", 32'(M_stall), 32'd0);
    chk("alu_nofault", 32'(M_mem_fault), 32'd0);
    cyc();

    // Timeout: accepted LW, no response for WAIT_LIMIT cycles
    M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0;
    M_funct3 = 3'b010; M_alu_out = 32'h300; dm_req_ready = 1'b1; dm_rsp_valid = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_wait_stall", 32'(M_stall), 32'd1);
      chk("to_wait_nofault", 32'(M_mem_fault), 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("to_done_stall", 32'(M_stall), 32'd0);
    chk("to_done_fault", 32'(M_mem_fault), 32'd1);
    chk("to_done_ld", M_load_data, 32'h0);
    cyc();
    M_valid = 1'b0;
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("to_idle_fault", 32'(M_mem_fault), 32'd0);
    cyc();
    dm_rsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_rsp_ignored", M_load_data, 32'h0);
    cyc();

    // Set a non-zero result, then reset mid-access in WAIT
    load_op(3'b010, 32'h400, 32'h0BAD_F00D, 32'h0BAD_F00D);
    M_valid = 1'b1; M_mem_read = 1'b1; M_funct3 = 3'b010; M_alu_out = 32'h100;
    dm_req_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("pre_rst_wait_stall", 32'(M_stall), 32'd1);
    rst = 1'b1; M_valid = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_stall", 32'(M_stall), 32'd0);
    chk("rst_wait_noreq", 32'(dm_req_valid), 32'd0);
    chk("rst_wait_ld", M_load_data, 32'h0);
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'hCAFE_F00D;
    cyc();
    dm_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_ignored", M_load_data, 32'h0);
    chk("late_rsp_nostall", 32'(M_stall), 32'd0);
    cyc();
    load_op(3'b000, 32'h102, 32'h00FE_0000, 32'hFFFF_FFFE);
    M_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
